// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2-to-memory line bridge: geometry, FSM states
// and the beat address helper.
package l2_mem_pkg;

    localparam int TNUM     = 18;
    localparam int INUM     = 8;
    localparam int LINE_W   = 512;
    localparam int BEAT_W   = 32;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int OFFSET_W = 6;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        RD_BURST = 3'd2,
        DONE     = 3'd3,
        GAP      = 3'd4
    } state_e;

    // Byte address of beat cnt within the line {tag, index}.
    function automatic logic [31:0] line_addr(
        input logic [TNUM-1:0]  tag,
        input logic [INUM-1:0]  index,
        input logic [CNT_W-1:0] cnt
    );
        return {tag, index, {OFFSET_W{1'b0}}} + {{(32-CNT_W-2){1'b0}}, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/l2_mem_beat_shifter.sv
// Line working register and beat counter: serves write beats out of a
// latched line and assembles read beats into the same register.
module l2_mem_beat_shifter
    import l2_mem_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_advance,
    input  logic              i_insert,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [BEAT_W-1:0] o_beat,
    output logic [LINE_W-1:0] o_line_ins
);

    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;

    // Beat counter: cleared on load/clear, steps on every accepted beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!nrst)
            r_cnt <= '0;
        else if (i_clr || i_load)
            r_cnt <= '0;
        else if (i_advance)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Line register: latched whole for writes, filled beat by beat for reads.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every bit is written before it is ever consumed.
        if (i_load)
            r_line <= i_line;
        else if (i_advance && i_insert)
            r_line <= o_line_ins;
    end

    // Current line with the incoming read beat merged at the counter slot.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned.
        o_line_ins = r_line;
        o_line_ins[int'(r_cnt)*BEAT_W +: BEAT_W] = i_beat;
    end

    assign o_cnt  = r_cnt;
    assign o_beat = r_line[int'(r_cnt)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/l2_mem_bridge.sv
// Bridge between L2 line requests and a 32-bit external memory port:
// each 512-bit line moves as 16 beats, finished by a one-cycle ready pulse.
module l2_mem_bridge
    import l2_mem_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              read_L2_MEM,
    input  logic              write_L2_MEM,
    input  logic [TNUM-1:0]   tag_L2_MEM,
    input  logic [INUM-1:0]   index_L2_MEM,
    input  logic [TNUM-1:0]   write_tag_L2_MEM,
    input  logic [INUM-1:0]   write_index_L2_MEM,
    input  logic [LINE_W-1:0] write_data_L2_MEM,
    output logic              ready_MEM_L2,
    output logic [LINE_W-1:0] read_data_MEM_L2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [BEAT_W-1:0] mem_rdata
);

    state_e            r_state;
    logic [TNUM-1:0]   r_tag;
    logic [INUM-1:0]   r_index;
    logic [LINE_W-1:0] r_rd_line;

    logic              w_burst;
    logic              w_last;
    logic              w_load;
    logic              w_clr;
    logic              w_advance;
    logic [CNT_W-1:0]  w_cnt;
    logic [BEAT_W-1:0] w_beat;
    logic [LINE_W-1:0] w_line_ins;

    assign w_burst   = (r_state == WR_BURST) || (r_state == RD_BURST);
    assign w_advance = w_burst && mem_ack;
    assign w_last    = w_advance && (w_cnt == CNT_W'(BEATS-1));
    // Write-back wins when both requests are up in IDLE.
    assign w_load    = (r_state == IDLE) && write_L2_MEM;
    assign w_clr     = (r_state == IDLE);

    l2_mem_beat_shifter u_shifter (
        .clk        (clk),
        .nrst       (nrst),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_line     (write_data_L2_MEM),
        .i_advance  (w_advance),
        .i_insert   (r_state == RD_BURST),
        .i_beat     (mem_rdata),
        .o_cnt      (w_cnt),
        .o_beat     (w_beat),
        .o_line_ins (w_line_ins)
    );

    // Transaction FSM: latch the request, run the burst, pulse ready, rest one cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_tag     <= '0;
            r_index   <= '0;
            r_rd_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_L2_MEM) begin
                        r_tag   <= write_tag_L2_MEM;
                        r_index <= write_index_L2_MEM;
                        r_state <= WR_BURST;
                    end else if (read_L2_MEM) begin
                        r_tag   <= tag_L2_MEM;
                        r_index <= index_L2_MEM;
                        r_state <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (w_last)
                        r_state <= DONE;
                end
                RD_BURST: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        r_rd_line <= w_line_ins;
                    end
                end
                DONE:    r_state <= GAP;
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_MEM_L2     = (r_state == DONE);
    assign read_data_MEM_L2 = r_rd_line;
    assign mem_req          = w_burst;
    assign mem_we           = (r_state == WR_BURST);
    assign mem_addr         = w_burst ? line_addr(r_tag, r_index, w_cnt) : '0;
    assign mem_wdata        = (r_state == WR_BURST) ? w_beat : '0;

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed bench for l2_mem_bridge: table-driven single transactions plus
// hand-written sequences for read+write, reset mid-burst and held requests.
module tb_l2_mem_bridge;
    import l2_mem_pkg::*;

    logic              clk = 1'b0;
    logic              nrst;
    logic              read_L2_MEM;
    logic              write_L2_MEM;
    logic [TNUM-1:0]   tag_L2_MEM;
    logic [INUM-1:0]   index_L2_MEM;
    logic [TNUM-1:0]   write_tag_L2_MEM;
    logic [INUM-1:0]   write_index_L2_MEM;
    logic [LINE_W-1:0] write_data_L2_MEM;
    logic              ready_MEM_L2;
    logic [LINE_W-1:0] read_data_MEM_L2;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [BEAT_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    l2_mem_bridge dut (
        .clk                (clk),
        .nrst               (nrst),
        .read_L2_MEM        (read_L2_MEM),
        .write_L2_MEM       (write_L2_MEM),
        .tag_L2_MEM         (tag_L2_MEM),
        .index_L2_MEM       (index_L2_MEM),
        .write_tag_L2_MEM   (write_tag_L2_MEM),
        .write_index_L2_MEM (write_index_L2_MEM),
        .write_data_L2_MEM  (write_data_L2_MEM),
        .ready_MEM_L2       (ready_MEM_L2),
        .read_data_MEM_L2   (read_data_MEM_L2),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ready_cnt = 0;
    int          unstable = 0;
    int          wait_n = 0;
    logic [31:0] rd_base = 32'h0;
    logic [31:0] addr_q[$];
    logic        we_q[$];
    logic [31:0] wd_q[$];

    typedef struct {
        bit          wr;
        logic [17:0] tag;
        logic [7:0]  idx;
        logic [31:0] base;
        int          wn;
        bit          scramble;
        logic [31:0] exp_addr0;
        int          exp_edges;
    } txn_t;

    txn_t tbl[4];

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input int budget, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (ready_MEM_L2 !== 1'b1 && edges < budget);
    endtask

    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < BEATS; k++)
            l[k*BEAT_W +: BEAT_W] = base + 32'(k);
        return l;
    endfunction

    task automatic clear_log();
        addr_q.delete();
        we_q.delete();
        wd_q.delete();
    endtask

    // Memory model: acks after wait_n idle cycles per beat, logs accepted
    // beats, flags fields that move while a beat is pending, counts ready.
    initial begin
        int          wc;
        logic        p_req, p_ack, p_we;
        logic [31:0] p_addr, p_wd;
        wc = 0; p_req = 0; p_ack = 0; p_we = 0; p_addr = 0; p_wd = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (p_req && !p_ack && mem_req === 1'b1 &&
                (mem_addr !== p_addr || mem_wdata !== p_wd || mem_we !== p_we))
                unstable++;
            if (ready_MEM_L2 === 1'b1)
                ready_cnt++;
            mem_rdata = rd_base + 32'(mem_addr[5:2]);
            if (mem_req === 1'b1 && wc >= wait_n) begin
                mem_ack = 1'b1;
                wc = 0;
                addr_q.push_back(mem_addr);
                we_q.push_back(mem_we);
                wd_q.push_back(mem_wdata);
            end else begin
                mem_ack = 1'b0;
                if (mem_req === 1'b1) wc++;
                else wc = 0;
            end
            p_req = (mem_req === 1'b1);
            p_ack = mem_ack;
            p_we = mem_we;
            p_addr = mem_addr;
            p_wd = mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int                edges;
        int                e_sum;
        logic [LINE_W-1:0] exp_rd;

        tbl[0] = '{1'b0, 18'h00001, 8'h05, 32'hA000_0000, 0, 1'b0, 32'h0000_4140, 17};
        tbl[1] = '{1'b1, 18'h3FFFF, 8'hFF, 32'h5500_0000, 2, 1'b1, 32'hFFFF_FFC0, 49};
        tbl[2] = '{1'b0, 18'h2ABCD, 8'h3C, 32'hC0DE_0000, 1, 1'b1, 32'hAAF3_4F00, 33};
        tbl[3] = '{1'b1, 18'h00000, 8'h01, 32'h1234_0000, 0, 1'b0, 32'h0000_0040, 17};

        nrst = 1'b0;
        read_L2_MEM = 1'b0;
        write_L2_MEM = 1'b0;
        tag_L2_MEM = '0;
        index_L2_MEM = '0;
        write_tag_L2_MEM = '0;
        write_index_L2_MEM = '0;
        write_data_L2_MEM = '0;
        tick();
        tick();
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst ready", ready_MEM_L2, 1'b0);
        check("rst read_data", read_data_MEM_L2, '0);
        nrst = 1'b1;
        tick();
        exp_rd = '0;

        // Table-driven single transactions.
        for (int i = 0; i < 4; i++) begin
            clear_log();
            ready_cnt = 0;
            unstable = 0;
            wait_n = tbl[i].wn;
            rd_base = tbl[i].base;
            write_L2_MEM = tbl[i].wr;
            read_L2_MEM = !tbl[i].wr;
            if (tbl[i].wr) begin
                write_tag_L2_MEM = tbl[i].tag;
                write_index_L2_MEM = tbl[i].idx;
                write_data_L2_MEM = make_line(tbl[i].base);
                tag_L2_MEM = ~tbl[i].tag;
                index_L2_MEM = ~tbl[i].idx;
            end else begin
                tag_L2_MEM = tbl[i].tag;
                index_L2_MEM = tbl[i].idx;
                write_tag_L2_MEM = ~tbl[i].tag;
                write_index_L2_MEM = ~tbl[i].idx;
                write_data_L2_MEM = make_line(~tbl[i].base);
            end
            edges = 0;
            while (ready_MEM_L2 !== 1'b1 && edges < 400) begin
                tick();
                edges++;
                if (tbl[i].scramble && edges == 4) begin
                    tag_L2_MEM = ~tag_L2_MEM;
                    index_L2_MEM = ~index_L2_MEM;
                    write_tag_L2_MEM = ~write_tag_L2_MEM;
                    write_index_L2_MEM = ~write_index_L2_MEM;
                    write_data_L2_MEM = ~write_data_L2_MEM;
                end
            end
            check($sformatf("t%0d latency", i), edges, tbl[i].exp_edges);
            read_L2_MEM = 1'b0;
            write_L2_MEM = 1'b0;
            tick();
            tick();
            tick();
            check($sformatf("t%0d ready pulses", i), ready_cnt, 1);
            check($sformatf("t%0d beats", i), addr_q.size(), BEATS);
            for (int k = 0; k < BEATS && k < addr_q.size(); k++) begin
                check($sformatf("t%0d addr%0d", i, k), addr_q[k], tbl[i].exp_addr0 + 32'(4*k));
                check($sformatf("t%0d we%0d", i, k), we_q[k], tbl[i].wr);
                if (tbl[i].wr)
                    check($sformatf("t%0d wdata%0d", i, k), wd_q[k], tbl[i].base + 32'(k));
            end
            check($sformatf("t%0d stable", i), unstable, 0);
            if (!tbl[i].wr)
                exp_rd = make_line(tbl[i].base);
            check($sformatf("t%0d read_data", i), read_data_MEM_L2, exp_rd);
        end

        // Simultaneous write-back + refill: write first, then the read.
        clear_log();
        ready_cnt = 0;
        wait_n = 0;
        rd_base = 32'hBEEF_0000;
        tag_L2_MEM = 18'h00010;
        index_L2_MEM = 8'h20;
        write_tag_L2_MEM = 18'h00AAA;
        write_index_L2_MEM = 8'h11;
        write_data_L2_MEM = make_line(32'h7700_0000);
        read_L2_MEM = 1'b1;
        write_L2_MEM = 1'b1;
        wait_ready(400, edges);
        check("rw first latency", edges, 17);
        check("rw first addr", (addr_q.size() > 0) ? addr_q[0] : 32'hDEAD_DEAD, 32'h02AA_8440);
        check("rw first we", (we_q.size() > 0) ? we_q[0] : 1'b0, 1'b1);
        check("rw first wdata15", (wd_q.size() > 15) ? wd_q[15] : 32'h0, 32'h7700_000F);
        write_L2_MEM = 1'b0;
        clear_log();
        wait_ready(400, edges);
        check("rw second spacing", edges, 19);
        check("rw second addr", (addr_q.size() > 0) ? addr_q[0] : 32'hDEAD_DEAD, 32'h0004_0800);
        check("rw second we", (we_q.size() > 0) ? we_q[0] : 1'b1, 1'b0);
        read_L2_MEM = 1'b0;
        tick();
        tick();
        tick();
        check("rw ready pulses", ready_cnt, 2);
        exp_rd = make_line(32'hBEEF_0000);
        check("rw read_data", read_data_MEM_L2, exp_rd);

        // Reset in the middle of a refill, then a clean refill from beat 0.
        clear_log();
        ready_cnt = 0;
        wait_n = 0;
        rd_base = 32'h0D00_0000;
        tag_L2_MEM = 18'h00002;
        index_L2_MEM = 8'h00;
        read_L2_MEM = 1'b1;
        edges = 0;
        while (addr_q.size() < 7 && edges < 100) begin
            tick();
            edges++;
        end
        check("mid reached beat7", addr_q.size(), 7);
        nrst = 1'b0;
        tick();
        check("mid rst mem_req", mem_req, 1'b0);
        check("mid rst ready", ready_MEM_L2, 1'b0);
        check("mid rst read_data", read_data_MEM_L2, '0);
        clear_log();
        ready_cnt = 0;
        nrst = 1'b1;
        wait_ready(400, edges);
        check("mid restart latency", edges, 17);
        check("mid restart addr0", (addr_q.size() > 0) ? addr_q[0] : 32'hDEAD_DEAD, 32'h0000_8000);
        check("mid restart beats", addr_q.size(), BEATS);
        read_L2_MEM = 1'b0;
        tick();
        tick();
        tick();
        check("mid ready pulses", ready_cnt, 1);
        exp_rd = make_line(32'h0D00_0000);
        check("mid read_data", read_data_MEM_L2, exp_rd);

        // Request held past GAP: a second refill starts only from IDLE.
        clear_log();
        ready_cnt = 0;
        wait_n = 0;
        rd_base = 32'h600D_0000;
        tag_L2_MEM = 18'h00003;
        index_L2_MEM = 8'h07;
        read_L2_MEM = 1'b1;
        wait_ready(400, edges);
        check("held first latency", edges, 17);
        tick();
        check("held gap mem_req", mem_req, 1'b0);
        tick();
        check("held idle mem_req", mem_req, 1'b0);
        tick();
        check("held restart mem_req", mem_req, 1'b1);
        read_L2_MEM = 1'b0;
        wait_ready(400, edges);
        e_sum = edges + 3;
        check("held ready spacing", e_sum, 19);
        tick();
        tick();
        tick();
        check("held ready pulses", ready_cnt, 2);
        exp_rd = make_line(32'h600D_0000);
        check("held read_data", read_data_MEM_L2, exp_rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
